// File: rtl/alu_regfile_pkg.sv
// Shared types and constants for the CPU register file and IDU.
// Register/pair/IDU selectors, flag bit positions, widths.
package alu_regfile_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int FLAG_WIDTH = 4;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  localparam logic [15:0] SP_RESET_DEF = 16'hFFFE;

  typedef enum logic [2:0] {
    REG_B = 3'd0,
    REG_C = 3'd1,
    REG_D = 3'd2,
    REG_E = 3'd3,
    REG_H = 3'd4,
    REG_L = 3'd5,
    REG_F = 3'd6,
    REG_A = 3'd7
  } reg_sel_t;

  typedef enum logic [1:0] {
    PAIR_BC = 2'd0,
    PAIR_DE = 2'd1,
    PAIR_HL = 2'd2,
    PAIR_SP = 2'd3
  } pair_sel_t;

  typedef enum logic [1:0] {
    IDU_NONE = 2'd0,
    IDU_INC  = 2'd1,
    IDU_DEC  = 2'd2
  } idu_op_t;

endpackage

// File: rtl/alu_regfile_if.sv
// Sequencer/ALU-facing bundle of the register file.
// master: sequencer+ALU side; slave: register file.
interface alu_regfile_if;
  import alu_regfile_pkg::*;

  logic                  phi_en;
  reg_sel_t              rd_a_sel;
  reg_sel_t              rd_b_sel;
  logic [DATA_WIDTH-1:0] operand_A;
  logic [DATA_WIDTH-1:0] operand_B;
  logic                  wb_valid;
  reg_sel_t              wb_sel;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [FLAG_WIDTH-1:0] wb_flags;
  logic [FLAG_WIDTH-1:0] wb_flag_mask;
  pair_sel_t             pair_sel;
  idu_op_t               idu_op;
  logic                  ld16_valid;
  logic [15:0]           ld16_data;
  logic [15:0]           pair_out;
  logic [FLAG_WIDTH-1:0] flags;

  modport master (
    output phi_en, rd_a_sel, rd_b_sel,
    output wb_valid, wb_sel, wb_data,
    output wb_flags, wb_flag_mask,
    output pair_sel, idu_op,
    output ld16_valid, ld16_data,
    input  operand_A, operand_B,
    input  pair_out, flags
  );

  modport slave (
    input  phi_en, rd_a_sel, rd_b_sel,
    input  wb_valid, wb_sel, wb_data,
    input  wb_flags, wb_flag_mask,
    input  pair_sel, idu_op,
    input  ld16_valid, ld16_data,
    output operand_A, operand_B,
    output pair_out, flags
  );

endinterface

// File: rtl/alu_regfile_idu.sv
// Combinational 16-bit increment/decrement with wrap.
// op: idu_op_t, din: pair value, dout: result.
module alu_regfile_idu
  import alu_regfile_pkg::*;
(
  input  idu_op_t     op,
  input  logic [15:0] din,
  output logic [15:0] dout
);

  always_comb begin
    dout = din;
    case (op)
      IDU_INC: dout = din + 16'd1;
      IDU_DEC: dout = din - 16'd1;
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/alu_regfile.sv
// CPU register file: bytes, flags, pairs, SP with IDU.
// clk, rst (async low), bus: alu_regfile_if.slave.
module alu_regfile
  import alu_regfile_pkg::*;
#(
  parameter logic [15:0] SP_RESET = SP_RESET_DEF
) (
  input  logic           clk,
  input  logic           rst,
  alu_regfile_if.slave   bus
);

  logic [15:0] bc, de, hl, sp;
  logic [15:0] bc_n, de_n, hl_n, sp_n;
  logic [7:0]  a, a_n;
  logic [3:0]  f, f_n;
  logic [7:0]  byte_v [8];
  logic [15:0] pair_v [4];
  logic [15:0] pair_cur;
  logic [15:0] idu_out;
  logic [15:0] p16;
  logic        upd16;

  always_comb begin
    byte_v[0] = bc[15:8];
    byte_v[1] = bc[7:0];
    byte_v[2] = de[15:8];
    byte_v[3] = de[7:0];
    byte_v[4] = hl[15:8];
    byte_v[5] = hl[7:0];
    byte_v[6] = {f, 4'b0000};
    byte_v[7] = a;
    pair_v[0] = bc;
    pair_v[1] = de;
    pair_v[2] = hl;
    pair_v[3] = sp;
  end

  assign pair_cur      = pair_v[bus.pair_sel];
  assign bus.operand_A = byte_v[bus.rd_a_sel];
  assign bus.operand_B = byte_v[bus.rd_b_sel];
  assign bus.pair_out  = pair_cur;
  assign bus.flags     = f;

  alu_regfile_idu u_idu (
    .op   (bus.idu_op),
    .din  (pair_cur),
    .dout (idu_out)
  );

  // 16-bit result lands first; a byte writeback
  // then overrides just its own half of the pair.
  always_comb begin
    bc_n  = bc;
    de_n  = de;
    hl_n  = hl;
    sp_n  = sp;
    a_n   = a;
    f_n   = f;
    p16   = bus.ld16_valid ? bus.ld16_data : idu_out;
    upd16 = bus.ld16_valid ||
            (bus.idu_op != IDU_NONE);
    if (upd16) begin
      unique case (bus.pair_sel)
        PAIR_BC: bc_n = p16;
        PAIR_DE: de_n = p16;
        PAIR_HL: hl_n = p16;
        PAIR_SP: sp_n = p16;
      endcase
    end
    if (bus.wb_valid) begin
      unique case (bus.wb_sel)
        REG_B: bc_n[15:8] = bus.wb_data;
        REG_C: bc_n[7:0]  = bus.wb_data;
        REG_D: de_n[15:8] = bus.wb_data;
        REG_E: de_n[7:0]  = bus.wb_data;
        REG_H: hl_n[15:8] = bus.wb_data;
        REG_L: hl_n[7:0]  = bus.wb_data;
        REG_F: f_n        = bus.wb_data[7:4];
        REG_A: a_n        = bus.wb_data;
      endcase
      if (bus.wb_sel != REG_F)
        f_n = (f & ~bus.wb_flag_mask) |
              (bus.wb_flags & bus.wb_flag_mask);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bc <= '0;
      de <= '0;
      hl <= '0;
      sp <= SP_RESET;
      a  <= '0;
      f  <= '0;
    end else if (bus.phi_en) begin
      bc <= bc_n;
      de <= de_n;
      hl <= hl_n;
      sp <= sp_n;
      a  <= a_n;
      f  <= f_n;
    end
  end

endmodule

// File: tb/tb_alu_regfile.sv
// Directed bench for alu_regfile.
// Hand-computed vectors; one chk task counts all.
module tb_alu_regfile;
  import alu_regfile_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  alu_regfile_if bus ();

  alu_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.phi_en       = 1'b0;
    bus.wb_valid     = 1'b0;
    bus.wb_sel       = REG_B;
    bus.wb_data      = 8'h00;
    bus.wb_flags     = 4'h0;
    bus.wb_flag_mask = 4'h0;
    bus.idu_op       = IDU_NONE;
    bus.ld16_valid   = 1'b0;
    bus.ld16_data    = 16'h0000;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wb(input logic phi,
                    input reg_sel_t s,
                    input logic [7:0] d,
                    input logic [3:0] fl,
                    input logic [3:0] m);
    bus.phi_en       = phi;
    bus.wb_valid     = 1'b1;
    bus.wb_sel       = s;
    bus.wb_data      = d;
    bus.wb_flags     = fl;
    bus.wb_flag_mask = m;
    step();
  endtask

  task automatic ld(input pair_sel_t p,
                    input logic [15:0] d);
    bus.phi_en     = 1'b1;
    bus.pair_sel   = p;
    bus.ld16_valid = 1'b1;
    bus.ld16_data  = d;
    step();
  endtask

  task automatic idu(input pair_sel_t p,
                     input idu_op_t op);
    bus.phi_en   = 1'b1;
    bus.pair_sel = p;
    bus.idu_op   = op;
    step();
  endtask

  task automatic rd(input reg_sel_t s,
                    input logic [7:0] exp,
                    input string tag);
    bus.rd_a_sel = s;
    #1;
    chk(tag, {8'h00, bus.operand_A},
        {8'h00, exp});
  endtask

  task automatic rp(input pair_sel_t p,
                    input logic [15:0] exp,
                    input string tag);
    bus.pair_sel = p;
    #1;
    chk(tag, bus.pair_out, exp);
  endtask

  task automatic rf(input logic [3:0] exp,
                    input string tag);
    #1;
    chk(tag, {12'h000, bus.flags},
        {12'h000, exp});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    bus.rd_a_sel = REG_B;
    bus.rd_b_sel = REG_B;
    bus.pair_sel = PAIR_BC;
    idle();
    #12;
    for (int i = 0; i < 8; i++) begin
      bus.rd_a_sel = reg_sel_t'(i[2:0]);
      bus.rd_b_sel = reg_sel_t'(3'(7 - i));
      #1;
      chk("rst_opa", {8'h00, bus.operand_A}, 16'h0);
      chk("rst_opb", {8'h00, bus.operand_B}, 16'h0);
    end
    rp(PAIR_SP, 16'hFFFE, "rst_sp");
    rp(PAIR_HL, 16'h0000, "rst_hl");
    rf(4'h0, "rst_flags");
    @(negedge clk);
    rst = 1'b1;

    // byte write with flags, then phi-gated no-op
    wb(1'b1, REG_A, 8'h3C, 4'b1010, 4'b1111);
    rd(REG_A, 8'h3C, "wr_a");
    rf(4'b1010, "wr_flags");
    wb(1'b0, REG_A, 8'h77, 4'b0101, 4'b1111);
    rd(REG_A, 8'h3C, "nophi_a");
    rf(4'b1010, "nophi_flags");

    // flag masking
    wb(1'b1, REG_B, 8'h99, 4'h0, 4'h0);
    rd(REG_B, 8'h99, "wr_b");
    rf(4'b1010, "mask0_flags");
    wb(1'b1, REG_F, 8'hF0, 4'h0, 4'h0);
    rf(4'b1111, "f_all");
    wb(1'b1, REG_B, 8'h00, 4'b0000, 4'b0001);
    rf(4'b1110, "mask_c");
    rd(REG_B, 8'h00, "b_zero");
    wb(1'b1, REG_F, 8'h5A, 4'b0000, 4'b1111);
    rf(4'b0101, "f_5a");
    rd(REG_F, 8'h50, "rd_f");

    // IDU wrap
    ld(PAIR_DE, 16'hFFFF);
    rp(PAIR_DE, 16'hFFFF, "ld_de");
    rd(REG_D, 8'hFF, "ld_d");
    idu(PAIR_DE, IDU_INC);
    rp(PAIR_DE, 16'h0000, "inc_wrap");
    rd(REG_D, 8'h00, "inc_d");
    rd(REG_E, 8'h00, "inc_e");
    rf(4'b0101, "idu_flags");
    ld(PAIR_SP, 16'h0000);
    rp(PAIR_SP, 16'h0000, "ld_sp");
    idu(PAIR_SP, IDU_DEC);
    rp(PAIR_SP, 16'hFFFF, "dec_wrap");
    idu(PAIR_SP, IDU_DEC);
    rp(PAIR_SP, 16'hFFFE, "dec_sp");

    // conflicts
    ld(PAIR_HL, 16'h12FF);
    bus.phi_en       = 1'b1;
    bus.pair_sel     = PAIR_HL;
    bus.idu_op       = IDU_INC;
    bus.wb_valid     = 1'b1;
    bus.wb_sel       = REG_H;
    bus.wb_data      = 8'h55;
    bus.wb_flag_mask = 4'h0;
    step();
    rp(PAIR_HL, 16'h5500, "hl_conf");
    rd(REG_L, 8'h00, "l_conf");
    rf(4'b0101, "conf_flags");
    bus.phi_en     = 1'b1;
    bus.pair_sel   = PAIR_BC;
    bus.ld16_valid = 1'b1;
    bus.ld16_data  = 16'hABCD;
    bus.idu_op     = IDU_DEC;
    step();
    rp(PAIR_BC, 16'hABCD, "ld_wins");
    rd(REG_C, 8'hCD, "ld_c");

    // async reset mid-op
    bus.rd_a_sel     = REG_A;
    bus.pair_sel     = PAIR_SP;
    bus.phi_en       = 1'b1;
    bus.wb_valid     = 1'b1;
    bus.wb_sel       = REG_A;
    bus.wb_data      = 8'hEE;
    bus.wb_flags     = 4'hF;
    bus.wb_flag_mask = 4'hF;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_a", {8'h00, bus.operand_A}, 16'h0);
    chk("arst_sp", bus.pair_out, 16'hFFFE);
    rf(4'h0, "arst_flags");
    @(posedge clk);
    #1;
    chk("arst_edge_a", {8'h00, bus.operand_A}, 16'h0);
    rf(4'h0, "arst_edge_f");
    idle();
    rp(PAIR_BC, 16'h0000, "arst_bc");
    @(negedge clk);
    rst = 1'b1;
    step();
    rd(REG_A, 8'h00, "post_idle_a");
    wb(1'b1, REG_A, 8'h42, 4'h0, 4'h0);
    rd(REG_A, 8'h42, "post_wr_a");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_regfile.md
Name: alu_regfile

Overview:
- CPU register file at the opposite end of the ALU interface from the ALU.
- Sources operand_A/operand_B to the ALU and sinks ALU result and flag writeback.
- Also holds the 16-bit pairs and SP, and performs IDU (increment/decrement unit) inc/dec on them.
- Sits between the instruction sequencer (which drives selects and strobes) and the ALU. All state updates occur on clk edges qualified by the 1 MHz phi tick.

Parameters:
- DATA_WIDTH, 8, register byte width (package constant; listed for clarity, not overridable).
- SP_RESET, 16'hFFFE, reset value of SP.

Ports:
- clk  in  1  4 MHz system clock.
- rst  in  1  asynchronous, active-low reset.
- phi_en  in  1  one-clk-wide strobe marking the M-cycle edge; state updates only when high.
- rd_a_sel  in  3  reg_sel_t, selects operand_A.
- rd_b_sel  in  3  reg_sel_t, selects operand_B.
- operand_A  out  DATA_WIDTH  combinational read of rd_a_sel.
- operand_B  out  DATA_WIDTH  combinational read of rd_b_sel.
- wb_valid  in  1  ALU writeback request.
- wb_sel  in  3  reg_sel_t writeback target.
- wb_data  in  DATA_WIDTH  ALU result.
- wb_flags  in  FLAG_WIDTH  ALU flags (Z, N, H, C indexed by package constants).
- wb_flag_mask  in  FLAG_WIDTH  per-flag update enable.
- pair_sel  in  2  pair_sel_t {BC, DE, HL, SP}.
- idu_op  in  2  idu_op_t {IDU_NONE, IDU_INC, IDU_DEC}.
- ld16_valid  in  1  direct 16-bit load of pair_sel.
- ld16_data  in  16  load value.
- pair_out  out  16  combinational read of pair_sel.
- flags  out  FLAG_WIDTH  current flag register.

Behaviour:
- Storage
  - Bytes B, C, D, E, H, L, A (reg_sel_t: B=0, C=1, D=2, E=3, H=4, L=5, F=6, A=7).
  - 4-bit flag register; 16-bit SP.
- Reset (rst low, asynchronous)
  - All bytes and flags = 0; SP = SP_RESET.
  - Outputs follow combinationally: operand_A/B = 0, pair_out = 0, or SP_RESET when pair_sel = SP.
- Reads
  - Purely combinational; no bypass. A write at edge N is visible after edge N.
  - Selecting F returns {flags, 4'b0000}.
  - The pair view of HL is {H, L}, likewise BC and DE.
- Updates occur only at posedge clk with phi_en = 1; with phi_en = 0 all inputs are ignored.
- Byte writeback (wb_valid = 1)
  - wb_sel != F: the target byte is written with wb_data. Independently, each flag bit i with wb_flag_mask[i] = 1 takes wb_flags[i]; other flag bits hold.
  - wb_sel == F: flags <= wb_data[7:4]. wb_flag_mask and wb_flags are ignored. Lower nibble is discarded.
- 16-bit path
  - ld16_valid = 1 loads ld16_data into pair_sel, else idu_op applies ±1 modulo 2^16.
  - Wrap: FFFF + 1 = 0000, 0000 - 1 = FFFF.
  - The IDU never touches flags.
  - ld16_valid and idu_op != IDU_NONE together: ld16 wins, and the IDU is ignored.
- Simultaneous byte writeback and 16-bit update on the same pair
  - The writeback wins on its targeted byte.
  - The other byte takes the corresponding byte of the 16-bit result.
  - Example: HL = 12FF, INC, wb to H = 55 → HL = 5500.
  - Writeback to A/F never conflicts with a pair.
- Reset asserted mid-cycle overrides any pending update. First update after release occurs on the next qualified edge.
- Latency: 0 cycles for reads; 1 qualified edge for writes.

Decomposition:
- gate_boy_pkg gains:
  - reg_sel_t (3-bit enum).
  - pair_sel_t (2-bit enum).
  - idu_op_t (2-bit enum).
  - SP_RESET default constant.
  - Reuse existing DATA_WIDTH, FLAG_WIDTH, Z, N, H, C.
- One natural sub-module: idu.
  - Combinational 16-bit inc/dec with wrap.
  - Shared later with PC logic.
- Register storage and write arbitration stay in alu_regfile.

Test Plan:
1. Reset: hold rst low, then release → operand_A = operand_B = 00 for all selects, pair_sel = SP gives pair_out = FFFE, flags = 0.
2. Byte write/read
   - Stimulus: phi_en = 1, wb_valid, wb_sel = A, wb_data = 3C, wb_flag_mask = 1111, wb_flags = {Z=1, N=0, H=1, C=0}.
   - Response: next cycle rd_a_sel = A gives 3C, flags = 1010. With phi_en = 0 the same stimulus causes no change.
3. Flag masking
   - Stimulus: flags = 1111, wb to B = 00, mask = 0001, wb_flags = 0000.
   - Response: flags = 1110, B = 00. A separate wb_sel = F, wb_data = 5A gives flags = 0101 and reads F = 50.
4. IDU wrap: ld16 DE = FFFF, then INC → DE = 0000 (D = 00, E = 00), flags unchanged. SP = 0000, then DEC → FFFF.
5. Conflicts
   - HL = 12FF, INC with wb H = 55 in the same edge → HL = 5500.
   - ld16 BC = ABCD with idu DEC in the same edge → BC = ABCD.
6. Async reset mid-op: assert rst between clk edges while wb_valid and phi_en are high → all registers clear immediately, and no write lands on the following edge.
